fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Write-side scheduler that shares the single write port of the team's async FIFO (wdata/winc/wfull) between NREQ requesters in the write clock domain. Round-robin arbitration with burst grants: the granted requester keeps the port until its last beat or MAXBURST beats. It drives the FIFO write port directly and throttles requesters on wfull through a valid/ready handshake.

Parameters:
DSIZE, 8, data width; must equal the FIFO DSIZE.
NREQ, 4, number of requesters; must be at least 2; need not be a power of two.
MAXBURST, 4, maximum beats per grant; must be at least 1.

Ports:
wclk  input  1  write-domain clock
wrst  input  1  synchronous reset, active-high
req_valid  input  NREQ  per-requester beat valid
req_data  input  NREQ*DSIZE  per-requester data; requester i occupies bits [i*DSIZE +: DSIZE]
req_last  input  NREQ  marks the last beat of the requester's packet
req_ready  output  NREQ  per-requester beat accepted
wfull  input  1  FIFO full flag
winc  output  1  FIFO write enable
wdata  output  DSIZE  FIFO write data
grant_id  output  $clog2(NREQ)  index of the current or last granted requester
busy  output  1  high while in BURST

Behaviour:
- Clock and reset: one clock, wclk. Reset wrst is synchronous and active-high.
- Reset values:
  - state = ARB
  - rr_ptr = 0, so requester 0 has highest priority first
  - grant_id = 0, busy = 0, beat_cnt = 0
  - winc = 0, req_ready = 0 (combinational outputs are forced low while wrst is high)
- States:
  - ARB: search req_valid starting at rr_ptr and wrapping NREQ-1 -> 0. Take the first set bit g.
    - If any bit is set: register grant_id = g, clear beat_cnt, go to BURST.
    - If none is set: stay in ARB.
    - No beat is transferred in ARB; there is exactly one arbitration cycle between bursts.
  - BURST:
    - req_ready[grant_id] = !wfull. All other req_ready bits are 0.
    - winc = req_valid[grant_id] && !wfull.
    - wdata = the req_data slice of grant_id, muxed combinationally (zero-latency write path).
    - A beat is transferred when winc = 1; beat_cnt increments on each beat.
    - The burst ends on the beat where req_last[grant_id] = 1 or beat_cnt == MAXBURST-1. On that edge: go to ARB and set rr_ptr = grant_id+1 (wraps to 0 after NREQ-1).
    - If the granted requester drops valid, the grant is held (no timeout) and winc = 0.
- wfull: while wfull = 1, winc = 0 and req_ready = 0; state and beat_cnt hold. A stalled beat completes in the first cycle wfull = 0 and valid = 1. winc is never asserted while wfull = 1.
- Simultaneous events:
  - In ARB, requests asserted in the same cycle are resolved by rr_ptr order.
  - A new req_valid from another requester during BURST waits for ARB.
- Reset mid-burst: the burst is abandoned without a partial flush. The next cycle is ARB with rr_ptr = 0. Any beats already written stay in the FIFO.
- Width rule: beat_cnt width is $clog2(MAXBURST+1). For MAXBURST = 1 every beat ends the burst.
- busy = (state == BURST), registered.

Optional Feature:
FIFO_WR_ARB_STATS_EN
- Defined: adds output stall_cnt[15:0], an adds-one counter for each cycle in BURST with req_valid[grant_id] && wfull. It saturates at 16'hFFFF and clears only on wrst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg:
  - state enum (ARB, BURST)
  - localparam helper for the grant index width
  - STALL_CNT_W = 16
- One sub-module, rr_pick: a purely combinational rotating priority search. Inputs: req vector and rr_ptr. Outputs: grant index and an any-request flag. It is reusable by the read-side scheduler.

Test Plan:
- Reset then a single requester: req_valid = 4'b0100, 3 beats 0xA1, 0xA2, 0xA3 with last on 0xA3 -> ARB cycle, then grant_id = 2, busy = 1, and winc high for 3 consecutive cycles with wdata A1, A2, A3. After that: busy = 0 and rr_ptr = 3.
- All 4 requesting, each with single-beat packets -> grant order 0, 1, 2, 3, 0. Each grant is separated by one ARB cycle with winc = 0.
- Requester 1 streams 10 beats with no last and MAXBURST = 4 -> the grant is released after 4 beats and requester 2 (also valid) is granted next. Requester 1 resumes only after its turn comes round again.
- wfull asserted for 5 cycles mid-burst after beat 2 -> winc = 0 and req_ready = 0 for those 5 cycles. Beat 3 is written in the first cycle after wfull falls. With the macro defined, stall_cnt = 5.
- wrst pulsed for 1 cycle during beat 2 of a requester-3 burst -> the next cycle shows busy = 0 and winc = 0. With requesters 0 and 3 both valid, requester 0 is granted first.
- Granted requester drops valid for 3 cycles mid-burst -> grant_id is unchanged and winc = 0. The burst resumes when valid returns, and no other requester is granted in between.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO-port schedulers.
package fifo_arb_pkg;

   typedef enum logic {
      ARB   = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int unsigned STALL_CNT_W = 16;

   // Index width for an n-entry requester vector (never narrower than one bit).
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority search: first set request at or after ptr_i, wrapping to 0.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [IW-1:0]   gnt_o,
   output logic            any_o
);

   int unsigned j;

   // Walk offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      gnt_o = '0;
      any_o = 1'b0;
      j     = 0;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         j = 32'(ptr_i) + 32'(i);
         if (j >= NREQ) j = j - NREQ;
         if (req_i[IW'(j)]) begin
            gnt_o = IW'(j);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst scheduler sharing one async-FIFO write port among NREQ requesters.
// Optional stall counter output enabled by FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned DSIZE    = 8,
   parameter int unsigned NREQ     = 4,
   parameter int unsigned MAXBURST = 4
) (
   input  logic                      wclk,
   input  logic                      wrst,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*DSIZE-1:0]     req_data,
   input  logic [NREQ-1:0]           req_last,
   output logic [NREQ-1:0]           req_ready,
   input  logic                      wfull,
   output logic                      winc,
   output logic [DSIZE-1:0]          wdata,
   output logic [$clog2(NREQ)-1:0]   grant_id,
`ifdef FIFO_WR_ARB_STATS_EN
   output logic [STALL_CNT_W-1:0]    stall_cnt,
`endif
   output logic                      busy
);

   localparam int unsigned GW = idx_w(NREQ);
   localparam int unsigned BW = $clog2(MAXBURST + 1);

   arb_state_e    state_q, state_d;
   logic [GW-1:0] rr_ptr_q, rr_ptr_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [BW-1:0] beat_q, beat_d;
   logic          busy_q, busy_d;
   logic [GW-1:0] pick_gnt;
   logic          pick_any;
   logic          valid_g, last_g;

   assign valid_g  = req_valid[grant_q];
   assign last_g   = req_last[grant_q];
   assign grant_id = grant_q;
   assign busy     = busy_q;

   rr_pick #(.NREQ(NREQ), .IW(GW)) u_pick (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .any_o (pick_any)
   );

   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_q  <= ARB;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         beat_q   <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         beat_q   <= beat_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      beat_d   = beat_q;
      unique case (state_q)
         ARB: begin
            if (pick_any) begin
               grant_d = pick_gnt;
               beat_d  = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            if (winc) begin
               beat_d = BW'(beat_q + 1'b1);
               if (last_g || beat_q == BW'(MAXBURST - 1)) begin
                  state_d  = ARB;
                  rr_ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : GW'(grant_q + 1'b1);
               end
            end
         end
         default: state_d = ARB;
      endcase
      busy_d = (state_d == BURST);
   end

   // Zero-latency write path from the granted requester straight to the FIFO.
   always_comb begin
      winc      = 1'b0;
      req_ready = '0;
      wdata     = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (grant_q == GW'(i)) wdata = req_data[i*DSIZE +: DSIZE];
      end
      if (!wrst && state_q == BURST) begin
         winc               = valid_g && !wfull;
         req_ready[grant_q] = !wfull;
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [STALL_CNT_W-1:0] stall_q;

   always_ff @(posedge wclk) begin
      if (wrst) begin
         stall_q <= '0;
      end else if (state_q == BURST && valid_g && wfull && stall_q != '1) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a transaction-level scheduling model.
module tb_fifo_wr_arbiter;

   localparam int DSIZE    = 8;
   localparam int NREQ     = 4;
   localparam int MAXBURST = 4;

   logic                  wclk;
   logic                  wrst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*DSIZE-1:0] req_data;
   logic [NREQ-1:0]       req_last;
   logic [NREQ-1:0]       req_ready;
   logic                  wfull;
   logic                  winc;
   logic [DSIZE-1:0]      wdata;
   logic [1:0]            grant_id;
   logic                  busy;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [15:0]           stall_cnt;
`endif

   fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
      .wclk      (wclk),
      .wrst      (wrst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .wfull     (wfull),
      .winc      (winc),
      .wdata     (wdata),
      .grant_id  (grant_id),
`ifdef FIFO_WR_ARB_STATS_EN
      .stall_cnt (stall_cnt),
`endif
      .busy      (busy)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   int n_vec = 0;
   int n_err = 0;

   // Model: who owns the port, whose turn is next, beats in this grant.
   bit m_burst;
   int m_gid, m_ptr, m_beats, m_stall;

   // Requester sources.
   bit         src_v [NREQ];
   logic [7:0] src_d [NREQ];
   bit         src_l [NREQ];

   logic [3:0] k_mask;
   int p_valid, p_last, p_full, p_rst, p_drop;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic new_beat(input int i);
      src_d[i] = 8'($urandom);
      src_l[i] = ($urandom_range(99) < p_last);
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]                = src_v[i];
         req_data[i*DSIZE +: DSIZE]  = src_d[i];
         req_last[i]                 = src_l[i];
      end
   endtask

   task automatic model_reset();
      m_burst = 0;
      m_gid   = 0;
      m_ptr   = 0;
      m_beats = 0;
      m_stall = 0;
   endtask

   task automatic run_phase(input int cycles, input logic [3:0] mask, input int pv,
                            input int pl, input int pf, input int pr, input int pd);
      k_mask = mask; p_valid = pv; p_last = pl; p_full = pf; p_rst = pr; p_drop = pd;
      for (int i = 0; i < NREQ; i++) if (!mask[i]) src_v[i] = 0;
      for (int c = 0; c < cycles; c++) begin
         bit         exp_winc;
         logic [3:0] exp_rdy;
         bit         hit;
         @(posedge wclk);
         #1;
         wrst  = ($urandom_range(99) < p_rst);
         wfull = ($urandom_range(99) < p_full);
         drive();
         #3;
         exp_winc = !wrst && m_burst && src_v[m_gid] && !wfull;
         exp_rdy  = (!wrst && m_burst && !wfull) ? 4'(1 << m_gid) : 4'd0;
         check_val("busy", 32'(busy), 32'(m_burst));
         check_val("grant_id", 32'(grant_id), 32'(m_gid));
         check_val("winc", 32'(winc), 32'(exp_winc));
         check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
         if (exp_winc) check_val("wdata", 32'(wdata), 32'(src_d[m_gid]));
`ifdef FIFO_WR_ARB_STATS_EN
         check_val("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
         // Advance the model by one clock.
         if (wrst) begin
            model_reset();
         end else begin
            if (m_burst && src_v[m_gid] && wfull && m_stall < 65535) m_stall++;
            if (!m_burst) begin
               hit = 0;
               for (int k = 0; k < NREQ; k++) begin
                  if (!hit && src_v[(m_ptr + k) % NREQ]) begin
                     hit   = 1;
                     m_gid = (m_ptr + k) % NREQ;
                  end
               end
               if (hit) begin
                  m_burst = 1;
                  m_beats = 0;
               end
            end else if (exp_winc) begin
               m_beats++;
               if (src_l[m_gid] || m_beats == MAXBURST) begin
                  m_burst = 0;
                  m_ptr   = (m_gid + 1) % NREQ;
               end
            end
         end
         // Sources react to this cycle's handshake.
         for (int i = 0; i < NREQ; i++) begin
            if (exp_rdy[i] && src_v[i]) begin
               src_v[i] = k_mask[i] && ($urandom_range(99) < p_valid);
               new_beat(i);
            end else if (src_v[i] && $urandom_range(99) < p_drop) begin
               src_v[i] = 0;
            end else if (!src_v[i] && k_mask[i] && $urandom_range(99) < p_valid) begin
               src_v[i] = 1;
               new_beat(i);
            end
         end
      end
   endtask

   initial begin
      wrst  = 1'b1;
      wfull = 1'b0;
      p_last = 0;
      for (int i = 0; i < NREQ; i++) begin
         src_v[i] = 0;
         src_d[i] = '0;
         src_l[i] = 0;
      end
      drive();
      repeat (2) @(posedge wclk);
      #1;
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_grant_id", 32'(grant_id), 32'd0);
      check_val("rst_winc", 32'(winc), 32'd0);
      check_val("rst_req_ready", 32'(req_ready), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
      check_val("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      model_reset();

      // Lone requester 2 with short packets.
      run_phase(40, 4'b0100, 100, 30, 0, 0, 0);
      // Everyone requesting single-beat packets: strict rotation.
      run_phase(40, 4'b1111, 100, 100, 0, 0, 0);
      // No last: grants capped at MAXBURST beats.
      run_phase(60, 4'b1111, 100, 0, 0, 0, 0);
      // Back-pressure from a frequently full FIFO.
      run_phase(200, 4'b1111, 80, 20, 40, 0, 0);
      // Valid drops while granted.
      run_phase(200, 4'b1010, 70, 25, 10, 0, 30);
      // Everything mixed, including resets mid-burst.
      run_phase(2000, 4'b1111, 60, 25, 25, 3, 15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
